cordic_iter_ctrl: RTL and testbench

Iteration sequencer for the CORDIC coprocessor datapath. Accepts a start request with an iteration count, drives the x/y/z register load and update enables, supplies the per-iteration shift/LUT index from an internal iteration counter, and presents the result through a valid/ack handshake. It sits between the coprocessor's bus-side command logic and the CORDIC shift-add datapath. It is the only block that sequences that datapath.

---
 rtl/cordic_iter_ctrl_pkg.sv | 16 +
 rtl/cordic_iter_ctrl_if.sv | 42 ++++
 rtl/cordic_iter_ctrl_cnt.sv | 26 ++
 rtl/cordic_iter_ctrl.sv | 119 +++++++++++
 tb/tb_cordic_iter_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_iter_ctrl_pkg.sv
// Shared types and defaults for the CORDIC iteration sequencer.
// Combinational only: no latency, no backpressure.
// Holds the FSM state encoding and the default iteration-count width.
package cordic_ctrl_pkg;

    localparam int ITER_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        ITER = 3'd2,
        POST = 3'd3,
        HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Command / datapath-control bundle between bus-side logic and the CORDIC sequencer.
// No logic, so no latency; the result is held by out_valid until out_ack.
// The abort wire exists only when CORDIC_CTRL_ABORT_EN is defined.
interface cordic_iter_ctrl_if
    import cordic_ctrl_pkg::*;
#(
    parameter int ITER_W = ITER_W_DEF
);
    logic              start;
    logic [ITER_W-1:0] iters;
`ifdef CORDIC_CTRL_ABORT_EN
    logic              abort;
`endif
    logic              out_ack;
    logic              ready;
    logic              ld_init;
    logic              iter_en;
    logic [ITER_W-1:0] iter_idx;
    logic              ld_out;
    logic              out_valid;

`ifdef CORDIC_CTRL_ABORT_EN
    modport master (
        output start, iters, abort, out_ack,
        input  ready, ld_init, iter_en, iter_idx, ld_out, out_valid
    );
    modport slave (
        input  start, iters, abort, out_ack,
        output ready, ld_init, iter_en, iter_idx, ld_out, out_valid
    );
`else
    modport master (
        output start, iters, out_ack,
        input  ready, ld_init, iter_en, iter_idx, ld_out, out_valid
    );
    modport slave (
        input  start, iters, out_ack,
        output ready, ld_init, iter_en, iter_idx, ld_out, out_valid
    );
`endif

endinterface

// File: rtl/cordic_iter_ctrl_cnt.sv
// Iteration index counter with synchronous clear and terminal-count compare.
// q updates one cycle after en/syn_clr; last_tick is a compare on the registered q.
// No backpressure: counts whenever en is high, clear wins over count.
module cordic_iter_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] q,
    output logic         last_tick
);

    always_ff @(posedge clk) begin
        if (reset || syn_clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

    assign last_tick = (q == last);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: INIT load, N micro-rotation enables, POST capture, HOLD result.
// Latency start->out_valid is N+3 cycles; out_valid holds until out_ack (no queued starts).
// Optional CORDIC_CTRL_ABORT_EN adds an abort that cancels an operation before HOLD.
module cordic_iter_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    cordic_iter_ctrl_if.slave         bus
);

    state_t            state;
    logic [ITER_W-1:0] iters_q;
    logic [ITER_W-1:0] cnt_q;
    logic              cnt_last;
    logic              cnt_clr;
    logic              cnt_en;
    logic              abort_hit;

    logic ready_r, ld_init_r, iter_en_r, ld_out_r, out_valid_r;

`ifdef CORDIC_CTRL_ABORT_EN
    assign abort_hit = bus.abort && (state == INIT || state == ITER || state == POST);
`else
    assign abort_hit = 1'b0;
`endif

    assign cnt_clr = (state == INIT) || abort_hit;
    assign cnt_en  = (state == ITER) && !cnt_last;

    // iters==0 never reaches ITER, so the wrapped compare value is never used.
    cordic_iter_cnt #(.W(ITER_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .syn_clr   (cnt_clr),
        .en        (cnt_en),
        .last      (iters_q - ITER_W'(1)),
        .q         (cnt_q),
        .last_tick (cnt_last)
    );

    // Output flags are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            iters_q     <= '0;
            ready_r     <= 1'b1;
            ld_init_r   <= 1'b0;
            iter_en_r   <= 1'b0;
            ld_out_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            ready_r     <= 1'b0;
            ld_init_r   <= 1'b0;
            iter_en_r   <= 1'b0;
            ld_out_r    <= 1'b0;
            out_valid_r <= 1'b0;
            if (abort_hit) begin
                state   <= IDLE;
                ready_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state     <= INIT;
                            iters_q   <= bus.iters;
                            ld_init_r <= 1'b1;
                        end else begin
                            ready_r <= 1'b1;
                        end
                    end
                    INIT: begin
                        if (iters_q == '0) begin
                            state    <= POST;
                            ld_out_r <= 1'b1;
                        end else begin
                            state     <= ITER;
                            iter_en_r <= 1'b1;
                        end
                    end
                    ITER: begin
                        if (cnt_last) begin
                            state    <= POST;
                            ld_out_r <= 1'b1;
                        end else begin
                            iter_en_r <= 1'b1;
                        end
                    end
                    POST: begin
                        state       <= HOLD;
                        out_valid_r <= 1'b1;
                    end
                    HOLD: begin
                        if (bus.out_ack) begin
                            state   <= IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            out_valid_r <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        ready_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ready     = ready_r;
    assign bus.ld_init   = ld_init_r;
    assign bus.iter_en   = iter_en_r;
    assign bus.ld_out    = ld_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.iter_idx  = cnt_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl against a cycle-offset timing model.
module tb_cordic_iter_ctrl;

    localparam int W = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    cordic_iter_ctrl_if #(.ITER_W(W)) bus();

    cordic_iter_ctrl #(.ITER_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected {ready, ld_init, iter_en, ld_out, out_valid} in cycle t+off after start accepted at edge t.
    function automatic logic [4:0] exp_flags(input int off, input int n);
        if (off == 1)     return 5'b01000;
        if (off <= 1 + n) return 5'b00100;
        if (off == 2 + n) return 5'b00010;
        return 5'b00001;
    endfunction

    function automatic logic [4:0] obs_flags();
        return {bus.ready, bus.ld_init, bus.iter_en, bus.ld_out, bus.out_valid};
    endfunction

    // Runs one operation from an IDLE negedge; returns at the negedge of the IDLE cycle after ack.
    task automatic run_op(input int n, input int ack_wait, input bit noisy);
        logic [4:0] ef;
        n_checks++;
        if (obs_flags() !== 5'b10000) begin
            n_fail++;
            $display("FAIL op_ready_before n=%0d: got %b want 10000", n, obs_flags());
        end
        bus.start = 1'b1;
        bus.iters = W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        for (int off = 1; off < 100; off++) begin
            ef = exp_flags(off, n);
            n_checks++;
            if (obs_flags() !== ef) begin
                n_fail++;
                $display("FAIL op_flags n=%0d off=%0d: got %b want %b", n, off, obs_flags(), ef);
            end
            if (ef[2]) begin
                n_checks++;
                if (bus.iter_idx !== W'(off - 2)) begin
                    n_fail++;
                    $display("FAIL op_idx n=%0d off=%0d: got %0d want %0d", n, off, bus.iter_idx, off - 2);
                end
            end
            if (noisy) begin
                bus.start = 1'($urandom);
                bus.iters = W'($urandom);
            end
            if (off >= 3 + n + ack_wait) begin
                bus.out_ack = 1'b1;
                @(negedge clk);
                bus.out_ack = 1'b0;
                bus.start   = 1'b0;
                n_checks++;
                if (obs_flags() !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL op_ready_after n=%0d: got %b want 10000", n, obs_flags());
                end
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_flags() !== 5'b10000 || bus.iter_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b idx=%0d want 10000 idx=0", obs_flags(), bus.iter_idx);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_flags() !== 5'b10000) begin
            n_fail++;
            $display("FAIL idle_no_start: got %b want 10000", obs_flags());
        end
        // out_ack outside HOLD must do nothing
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        n_checks++;
        if (obs_flags() !== 5'b10000) begin
            n_fail++;
            $display("FAIL stray_ack: got %b want 10000", obs_flags());
        end
    endtask

    task automatic test_basic();
        run_op(4, 0, 1'b0);
    endtask

    task automatic test_zero_iters();
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_max_iters();
        run_op((1 << W) - 1, 0, 1'b1);
    endtask

    task automatic test_hold_and_back_to_back();
        run_op(5, 10, 1'b0);
        run_op(3, 0, 1'b0);
        run_op(1, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_op(int'($urandom_range((1 << W) - 1, 0)), int'($urandom_range(4, 0)), 1'b1);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        bus.iters = W'(6);
        @(negedge clk);
        bus.start = 1'b0;
        for (int off = 1; off <= 4; off++) begin
            n_checks++;
            if (obs_flags() !== exp_flags(off, 6)) begin
                n_fail++;
                $display("FAIL rst_mid_pre off=%0d: got %b want %b", off, obs_flags(), exp_flags(off, 6));
            end
            if (off < 4) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (obs_flags() !== 5'b10000 || bus.iter_idx !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %b idx=%0d want 10000 idx=0", obs_flags(), bus.iter_idx);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_flags() !== 5'b10000) begin
                n_fail++;
                $display("FAIL rst_mid_quiet c=%0d: got %b want 10000", c, obs_flags());
            end
        end
    endtask

`ifdef CORDIC_CTRL_ABORT_EN
    task automatic test_abort();
        bus.start = 1'b1;
        bus.iters = W'(8);
        @(negedge clk);
        bus.start = 1'b0;
        for (int off = 1; off <= 5; off++) begin
            n_checks++;
            if (obs_flags() !== exp_flags(off, 8)) begin
                n_fail++;
                $display("FAIL abort_pre off=%0d: got %b want %b", off, obs_flags(), exp_flags(off, 8));
            end
            if (off < 5) @(negedge clk);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (obs_flags() !== 5'b10000 || bus.iter_idx !== '0) begin
            n_fail++;
            $display("FAIL abort_after: got %b idx=%0d want 10000 idx=0", obs_flags(), bus.iter_idx);
        end
        @(negedge clk);
        run_op(2, 1, 1'b0);
    endtask
`endif

    initial begin
        bus.start   = 1'b0;
        bus.iters   = '0;
        bus.out_ack = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
        bus.abort   = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_iters();
        test_max_iters();
        test_hold_and_back_to_back();
        test_random();
        test_reset_mid();
`ifdef CORDIC_CTRL_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Enables and strobes must never overlap.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (!$onehot0({bus.ld_init, bus.iter_en, bus.ld_out, bus.out_valid})) begin
                n_fail++;
                $display("FAIL exclusive_strobes: got %b want at most one set",
                         {bus.ld_init, bus.iter_en, bus.ld_out, bus.out_valid});
            end
        end
    end

endmodule
